// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the pipeline stage register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int PIPE_CTRL_W = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam logic [PIPE_CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Inter-stage pipeline register with valid/ready, stall, flush
//                and bubble insertion. Define PIPE_SKID_EN for a 2-entry skid
//                buffer with a registered In_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [CTRL_W-1:0] In_ctrl,
  input  logic [DATA_W-1:0] In_data,
  input  logic [REG_W-1:0]  In_reg,
  input  logic              Stall,
  input  logic              Flush,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [CTRL_W-1:0] Out_ctrl,
  output logic [DATA_W-1:0] Out_data,
  output logic [REG_W-1:0]  Out_reg,
  output logic [CNT_W-1:0]  Stall_cnt
);

  stage_state_t      r_state;
  stage_state_t      w_state_nxt;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_in;
  logic              w_bubble;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_out_data;
  logic [REG_W-1:0]  r_out_reg;

`ifdef PIPE_SKID_EN
  logic              w_load_skid;
  logic              w_pop_skid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [REG_W-1:0]  r_skid_reg;

  // Readiness comes only from the state flop, so Out_ready never reaches In_ready.
  assign In_ready = (r_state != FULL) & ~Stall & ~Flush;
`else
  assign In_ready = ~Stall & ~Flush & (Out_ready | ~Out_valid);
`endif

  assign Out_valid  = (r_state != EMPTY);
  assign w_in_fire  = In_valid & In_ready;
  assign w_out_fire = Out_valid & Out_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_bubble    = 1'b0;
`ifdef PIPE_SKID_EN
    w_load_skid = 1'b0;
    w_pop_skid  = 1'b0;
`endif
    if (Flush) begin
      w_state_nxt = EMPTY;
      w_bubble    = 1'b1;
    end else if (!Stall) begin
`ifdef PIPE_SKID_EN
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = BUSY;
            w_load_in   = 1'b1;
          end
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_load_in   = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = FULL;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
            w_bubble    = 1'b1;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_state_nxt = BUSY;
            w_pop_skid  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_bubble    = 1'b1;
        end
      endcase
`else
      if (w_in_fire) begin
        w_state_nxt = BUSY;
        w_load_in   = 1'b1;
      end else if (w_out_fire) begin
        w_state_nxt = EMPTY;
        w_bubble    = 1'b1;
      end
`endif
    end
  end

  // Bubbles clear only ctrl; data/reg keep their last value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_ctrl  <= '0;
      r_out_data  <= '0;
      r_out_reg   <= '0;
`ifdef PIPE_SKID_EN
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_reg  <= '0;
`endif
    end else begin
      if (w_bubble) begin
        r_out_ctrl <= CTRL_W'(CTRL_BUBBLE);
      end else if (w_load_in) begin
        r_out_ctrl <= In_ctrl;
        r_out_data <= In_data;
        r_out_reg  <= In_reg;
`ifdef PIPE_SKID_EN
      end else if (w_pop_skid) begin
        r_out_ctrl <= r_skid_ctrl;
        r_out_data <= r_skid_data;
        r_out_reg  <= r_skid_reg;
`endif
      end
`ifdef PIPE_SKID_EN
      if (w_load_skid) begin
        r_skid_ctrl <= In_ctrl;
        r_skid_data <= In_data;
        r_skid_reg  <= In_reg;
      end
`endif
    end
  end

  assign Out_ctrl = r_out_ctrl;
  assign Out_data = r_out_data;
  assign Out_reg  = r_out_reg;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .i_inc   (Stall | (Out_valid & ~Out_ready)),
    .o_count (Stall_cnt)
  );

endmodule

`default_nettype wire
